// File: rtl/fmadd_exponent_adder_pipe_if.sv
// Operand/result bundle for the FMADD exponent pipe: operand pair in, flagged exponent result out.
// The slave modport is the pipe's view and the master modport is the producer/consumer view.
interface fmadd_exponent_adder_pipe_if #(
    parameter int EXP = 8
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [EXP:0]   in_a;
    logic [EXP:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [EXP:0]   out_raw_exp;
    logic [EXP-1:0] out_exp;
    logic           out_sign;
    logic           out_underflow_check;
    logic           out_overflow;
    logic           out_zero;

    modport slave (
        input  flush, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_raw_exp, out_exp, out_sign,
               out_underflow_check, out_overflow, out_zero
    );

    modport master (
        output flush, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_raw_exp, out_exp, out_sign,
               out_underflow_check, out_overflow, out_zero
    );
endinterface

// File: rtl/fmadd_exponent_adder_pipe.sv
// Exponent sum, de-bias, product sign and range flags for the FMADD multiply stage; 2-cycle latency.
// Two-stage elastic pipe: S2 holds while out_ready is low, in_ready drops once both stages are full.
module fmadd_exponent_adder_pipe #(
    parameter int EXP   = 8,
    parameter int BIAS  = 127,
    parameter int GUARD = 24
) (
    input  logic                         clk,
    input  logic                         rst_l,
    fmadd_exponent_adder_pipe_if.slave   io
);
    // Thresholds live at EXP+2 bits so BIAS + 2^EXP - 1 cannot overflow.
    localparam logic [EXP+1:0] UF_LIM  = (EXP+2)'(BIAS - GUARD);
    localparam logic [EXP+1:0] OVF_LIM = (EXP+2)'(BIAS + (2**EXP) - 1);
    localparam logic [EXP+1:0] BIAS_W  = (EXP+2)'(BIAS);

    logic           s1_valid_q, s1_valid_d;
    logic [EXP:0]   s1_raw_q, s1_raw_d;
    logic           s1_sign_q, s1_sign_d;
    logic           s1_zero_q, s1_zero_d;

    logic           s2_valid_q, s2_valid_d;
    logic [EXP:0]   s2_raw_q, s2_raw_d;
    logic [EXP-1:0] s2_exp_q, s2_exp_d;
    logic           s2_sign_q, s2_sign_d;
    logic           s2_uf_q, s2_uf_d;
    logic           s2_ovf_q, s2_ovf_d;
    logic           s2_zero_q, s2_zero_d;

    logic           s1_adv, s2_adv, s1_load, s2_load;
    logic [EXP+1:0] raw_x;

    always_comb begin
        s2_adv  = !s2_valid_q || io.out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        s1_load = io.in_valid && s1_adv && !io.flush;
        s2_load = s1_valid_q && s2_adv;

        s1_valid_d = io.flush ? 1'b0 : (s1_adv ? io.in_valid : s1_valid_q);
        s2_valid_d = io.flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);

        s1_raw_d  = {1'b0, io.in_a[EXP-1:0]} + {1'b0, io.in_b[EXP-1:0]};
        s1_sign_d = io.in_a[EXP] ^ io.in_b[EXP];
        s1_zero_d = (io.in_a[EXP-1:0] == '0) || (io.in_b[EXP-1:0] == '0);

        raw_x     = {1'b0, s1_raw_q};
        s2_raw_d  = s1_raw_q;
        s2_sign_d = s1_sign_q;
        s2_zero_d = s1_zero_q;
        s2_uf_d   = raw_x < UF_LIM;
        s2_ovf_d  = raw_x >= OVF_LIM;

        if (s1_zero_q || (raw_x < BIAS_W)) begin
            s2_exp_d = '0;
        end else if (s2_ovf_d) begin
            s2_exp_d = '1;
        end else begin
            s2_exp_d = EXP'(raw_x - BIAS_W);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Data flops only move on advance; flush leaves their contents alone.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_raw_q  <= '0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s2_raw_q  <= '0;
            s2_exp_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_uf_q   <= 1'b0;
            s2_ovf_q  <= 1'b0;
            s2_zero_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_raw_q  <= s1_raw_d;
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
            end
            if (s2_load) begin
                s2_raw_q  <= s2_raw_d;
                s2_exp_q  <= s2_exp_d;
                s2_sign_q <= s2_sign_d;
                s2_uf_q   <= s2_uf_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_zero_q <= s2_zero_d;
            end
        end
    end

    assign io.in_ready            = s1_adv;
    assign io.out_valid           = s2_valid_q;
    assign io.out_raw_exp         = s2_raw_q;
    assign io.out_exp             = s2_exp_q;
    assign io.out_sign            = s2_sign_q;
    assign io.out_underflow_check = s2_uf_q;
    assign io.out_overflow        = s2_ovf_q;
    assign io.out_zero            = s2_zero_q;
endmodule

// File: tb/tb_fmadd_exponent_adder_pipe.sv
// Directed bench for the FMADD exponent pipe: hand-computed vectors, backpressure, flush and reset.
module tb_fmadd_exponent_adder_pipe;
    logic clk;
    logic rst_l;

    fmadd_exponent_adder_pipe_if #(.EXP(8)) io ();

    fmadd_exponent_adder_pipe #(.EXP(8), .BIAS(127), .GUARD(24)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .io    (io)
    );

    always #5 clk = ~clk;

    // flags packed as {sign, underflow_check, overflow, zero}
    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] raw;
        logic [7:0] ex;
        logic [3:0] flags;
    } vec_t;

    vec_t vt [10];
    int   bp [4] = '{0, 4, 5, 9};
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    endtask

    function automatic logic [3:0] out_flags();
        return {io.out_sign, io.out_underflow_check, io.out_overflow, io.out_zero};
    endfunction

    task automatic drive(input int i);
        io.in_a     = vt[i].a;
        io.in_b     = vt[i].b;
        io.in_valid = 1'b1;
    endtask

    // Expects an empty pipe, out_ready high, and to be called just after a rising edge.
    task automatic send_one(input int i);
        drive(i);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        chk($sformatf("v%0d_lat1_valid", i), 32'(io.out_valid), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_lat2_valid", i), 32'(io.out_valid), 32'd1);
        chk($sformatf("v%0d_raw", i), 32'(io.out_raw_exp), 32'(vt[i].raw));
        chk($sformatf("v%0d_exp", i), 32'(io.out_exp), 32'(vt[i].ex));
        chk($sformatf("v%0d_flags", i), 32'(out_flags()), 32'(vt[i].flags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          tx, rx;
        logic        acc, stalled_prev;
        logic [20:0] held;

        vt[0] = '{9'h082, 9'h178, 9'd250, 8'd123, 4'b1000};
        vt[1] = '{9'd50,  9'd50,  9'd100, 8'd0,   4'b0100};
        vt[2] = '{9'd52,  9'd51,  9'd103, 8'd0,   4'b0000};
        vt[3] = '{9'd127, 9'd0,   9'd127, 8'd0,   4'b0001};
        vt[4] = '{9'd200, 9'd200, 9'd400, 8'd255, 4'b0010};
        vt[5] = '{9'd191, 9'd190, 9'd381, 8'd254, 4'b0000};
        vt[6] = '{9'd191, 9'd191, 9'd382, 8'd255, 4'b0010};
        vt[7] = '{9'h100, 9'h100, 9'd0,   8'd0,   4'b0101};
        vt[8] = '{9'd255, 9'd255, 9'd510, 8'd255, 4'b0010};
        vt[9] = '{9'h17F, 9'd127, 9'd254, 8'd127, 4'b1000};

        clk          = 1'b0;
        rst_l        = 1'b0;
        io.flush     = 1'b0;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_raw", 32'(io.out_raw_exp), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) send_one(i);
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(io.out_valid), 32'd0);

        // Backpressure: out_ready low for the first cycles while 4 operands stream in.
        io.out_ready = 1'b0;
        tx = 0;
        rx = 0;
        stalled_prev = 1'b0;
        held = '0;
        drive(bp[0]);
        for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
            @(negedge clk);
            if (io.out_valid && !io.out_ready) begin
                if (stalled_prev)
                    chk("bp_hold", 32'({io.out_raw_exp, io.out_exp, out_flags()}), 32'(held));
                held = {io.out_raw_exp, io.out_exp, out_flags()};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (io.out_valid && io.out_ready) begin
                chk($sformatf("bp%0d_raw", rx), 32'(io.out_raw_exp), 32'(vt[bp[rx]].raw));
                chk($sformatf("bp%0d_exp", rx), 32'(io.out_exp), 32'(vt[bp[rx]].ex));
                chk($sformatf("bp%0d_flags", rx), 32'(out_flags()), 32'(vt[bp[rx]].flags));
                rx++;
            end
            if (cyc == 2) begin
                chk("bp_in_ready_low", 32'(io.in_ready), 32'd0);
                chk("bp_accepts_before_stall", 32'(tx), 32'd2);
            end
            acc = io.in_valid && io.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                tx++;
                if (tx < 4) drive(bp[tx]);
                else io.in_valid = 1'b0;
            end
            io.out_ready = (cyc >= 3);
        end
        chk("bp_rx_count", 32'(rx), 32'd4);
        chk("bp_tx_count", 32'(tx), 32'd4);
        chk("bp_no_dup", 32'(io.out_valid), 32'd0);

        // Flush with both stages full and a third operand offered.
        io.out_ready = 1'b0;
        drive(1);
        @(posedge clk); #1;
        drive(2);
        @(posedge clk); #1;
        drive(3);
        io.flush = 1'b1;
        @(posedge clk); #1;
        io.flush    = 1'b0;
        io.in_valid = 1'b0;
        chk("fl_out_valid", 32'(io.out_valid), 32'd0);
        chk("fl_in_ready", 32'(io.in_ready), 32'd1);
        io.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("fl_quiet%0d", k), 32'(io.out_valid), 32'd0);
        end

        // Flush into an empty pipe drops the operand presented with it.
        drive(4);
        io.flush = 1'b1;
        @(posedge clk); #1;
        io.flush    = 1'b0;
        io.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("fl_drop%0d", k), 32'(io.out_valid), 32'd0);
        end
        send_one(5);
        @(posedge clk); #1;

        // Asynchronous reset with both stages holding data.
        io.out_ready = 1'b0;
        drive(6);
        @(posedge clk); #1;
        drive(8);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        chk("rst_pre_full", 32'(io.out_valid), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(io.out_valid), 32'd0);
        chk("rst_mid_raw", 32'(io.out_raw_exp), 32'd0);
        chk("rst_mid_exp", 32'(io.out_exp), 32'd0);
        chk("rst_mid_flags", 32'(out_flags()), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_in_ready", 32'(io.in_ready), 32'd1);
        chk("rst_rel_out_valid", 32'(io.out_valid), 32'd0);
        send_one(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fmadd_exponent_adder_pipe.md
Name: fmadd_exponent_adder_pipe

Overview:
- Pipelined, parametrised exponent path for the FMADD multiply stage.
- Takes two {sign, exponent} operands and forms the raw exponent sum, the de-biased product exponent and the product sign.
- Produces underflow, overflow and zero-operand flags.
- Two-stage elastic pipeline with valid/ready handshake and flush; sits between operand unpack and the mantissa-multiply/normalise stages.

Parameters:
- EXP, 8, exponent field width (8 for bfloat16/float32).
- BIAS, 127, exponent bias subtracted from the raw sum.
- GUARD, 24, underflow margin; underflow_check asserts when raw sum < BIAS-GUARD (103 at defaults).

Ports:
- clk  input  1  clock, rising edge.
- rst_l  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept this cycle.
- in_a  input  EXP+1  {sign, exponent} of operand A; sign is the MSB.
- in_b  input  EXP+1  {sign, exponent} of operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_raw_exp  output  EXP+1  in_a[EXP-1:0]+in_b[EXP-1:0], no bias removed.
- out_exp  output  EXP  de-biased, saturated exponent.
- out_sign  output  1  in_a[EXP]^in_b[EXP].
- out_underflow_check  output  1  raw < BIAS-GUARD.
- out_overflow  output  1  raw-BIAS >= 2^EXP-1.
- out_zero  output  1  either exponent field is zero.

Behaviour:
- Reset (rst_l low, asynchronous): all pipeline valid bits and all output registers go to 0; in_ready is 1 once rst_l is high. Reset mid-operation discards all in-flight data.
- Stage 1 (S1) registers:
  - raw = zero-extended sum of the two exponent fields, EXP+1 bits, never wraps;
  - sign = XOR of the operand signs;
  - zero = (a_exp==0)|(b_exp==0).
- Stage 2 (S2) registers, computed from S1:
  - underflow_check = raw < BIAS-GUARD;
  - overflow = raw >= BIAS + 2^EXP - 1;
  - out_exp by priority: zero -> 0; else raw < BIAS -> 0; else overflow -> all ones; else raw-BIAS truncated to EXP bits.
  - Flags are independent of one another: zero and underflow_check may both be 1.
- All outputs come directly from S2 registers, with no combinational path from inputs to outputs except in_ready.
- Handshake:
  - s2_adv = !s2_valid | out_ready;
  - s1_adv = !s1_valid | s2_adv;
  - in_ready = s1_adv.
  - A transfer occurs when in_valid & in_ready, and the data is captured into S1.
  - S1 moves into S2 when s1_valid & s2_adv.
  - An output is consumed when out_valid & out_ready.
- Latency is 2 cycles from input acceptance to out_valid; throughput is 1 per cycle with out_ready high.
- Backpressure: with out_ready low, S2 holds and S1 fills; in_ready drops once both stages are valid. No data is lost or duplicated, and outputs stay stable while out_valid & !out_ready.
- out_valid = s2_valid.
- Flush:
  - clears s1_valid and s2_valid at the next edge;
  - overrides any same-cycle input acceptance, so an operand presented with flush is dropped;
  - does not clear data registers.
- Simultaneous flush and rst_l low: reset wins.
- Data registers load only on advance, which saves toggling.
- Arithmetic is unsigned. At defaults raw ranges 0..510 and fits in 9 bits. The BIAS+2^EXP-1 comparison is done at EXP+2 bits to avoid overflow in the constant.

Test Plan:
- Basic: in_a=9'h082 (+,130), in_b=9'h178 (-,120), out_ready=1 -> 2 cycles later out_valid=1, raw=250, out_exp=123, sign=1, all flags 0.
- Underflow: exps 50+50 -> raw=100, underflow_check=1, out_exp=0. Exps 52+51 -> raw=103, underflow_check=0, out_exp=0 (raw<127). Exps 127+0 -> zero=1, out_exp=0.
- Overflow: 200+200 -> raw=400, overflow=1, out_exp=255. 191+190 -> raw=381, overflow=0, out_exp=254. 191+191 -> raw=382, overflow=1, out_exp=255.
- Backpressure: stream 4 back-to-back operands with out_ready low for 3 cycles -> in_ready falls after 2 accepts; all 4 results emerge in order with no loss or duplicates; outputs hold steady while stalled.
- Flush: accept 2 operands, assert flush for 1 cycle together with a 3rd in_valid -> out_valid stays 0 and no result from any of the 3 appears; the next operand returns normally with 2-cycle latency.
- Reset mid-operation: pull rst_l low asynchronously with both stages full -> out_valid and all outputs are 0 immediately, and in_ready=1 after release.
